// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter: grants one of three bit-serial sources per packet, muxes it onto the line, appends EOP and an inter-packet gap.
// Optional bit-time watchdog is compiled in when USB_TX_TIMEOUT_EN is defined.
module usb_tx_arbiter #(
  parameter int MAX_BITS = 700,
  parameter int GAP_BITS = 4
) (
  input  logic       useClk,
  input  logic       resetN,
  input  logic       checkData,
  input  logic       reqHs,
  input  logic       reqDesc,
  input  logic       reqEp,
  input  logic       bitHs,
  input  logic       bitDesc,
  input  logic       bitEp,
  input  logic       oeHs,
  input  logic       oeDesc,
  input  logic       oeEp,
  input  logic       doneHs,
  input  logic       doneDesc,
  input  logic       doneEp,
  input  logic       ackIn,
  input  logic       setupIn,
  input  logic       clrErr,
  output logic [2:0] grant,
  output logic       toggleDesc,
  output logic       toggleEp,
  output logic       txBit,
  output logic       txOE,
  output logic       txSe0,
  output logic       busy,
  output logic       timeoutErr
);
  // state | meaning
  // IDLE  | line released, arbitrate on the next strobe
  // SEND  | granted source drives bit/oe through the mux
  // EOP   | SE0, SE0, then one J bit
  // GAP   | line released for GAP_BITS strobes
  typedef enum logic [1:0] {IDLE, SEND, EOP, GAP} stateT;
  typedef enum logic [1:0] {SRV_NONE, SRV_DESC, SRV_EP} servedT;

  stateT      state, stateNext;
  servedT     lastServed, lastServedNext;
  logic [1:0] eopCnt, eopCntNext;
  logic [3:0] gapCnt, gapCntNext;
  logic [2:0] grantNext;
  logic       txBitNext, txOENext, txSe0Next, busyNext;
  logic       muxBit, muxOE, grantedDone, timeoutHit;

  assign muxBit = (grantNext[0] & bitHs) | (grantNext[1] & bitDesc) | (grantNext[2] & bitEp);
  assign muxOE  = (grantNext[0] & oeHs)  | (grantNext[1] & oeDesc)  | (grantNext[2] & oeEp);
  assign grantedDone = (grant[0] & doneHs) | (grant[1] & doneDesc) | (grant[2] & doneEp);

`ifdef USB_TX_TIMEOUT_EN
  localparam logic [9:0] BitsTc = 10'(MAX_BITS - 1);
  logic [9:0] bitCnt;

  // done takes precedence when it lands on the terminal strobe
  assign timeoutHit = checkData && (state == SEND) && !grantedDone && (bitCnt == BitsTc);

  always_ff @(posedge useClk or negedge resetN) begin
    if (!resetN) begin
      bitCnt <= '0;
    end else if (checkData) begin
      if (state == IDLE) bitCnt <= '0;
      else if (state == SEND) bitCnt <= bitCnt + 10'd1;
    end
  end

  always_ff @(posedge useClk or negedge resetN) begin
    if (!resetN) timeoutErr <= 1'b0;
    else if (clrErr) timeoutErr <= 1'b0;
    else if (timeoutHit) timeoutErr <= 1'b1;
  end
`else
  logic [10:0] unusedCfg;
  assign unusedCfg  = {clrErr, 10'(MAX_BITS)};
  assign timeoutHit = 1'b0;
  assign timeoutErr = 1'b0;
`endif

  always_comb begin
    stateNext      = state;
    grantNext      = grant;
    eopCntNext     = eopCnt;
    gapCntNext     = gapCnt;
    lastServedNext = lastServed;
    if (checkData) begin
      unique case (state)
        IDLE: begin
          if (reqHs) begin
            grantNext = 3'b001;
            stateNext = SEND;
          end else if (reqDesc && (!reqEp || lastServed != SRV_DESC)) begin
            grantNext      = 3'b010;
            lastServedNext = SRV_DESC;
            stateNext      = SEND;
          end else if (reqEp) begin
            grantNext      = 3'b100;
            lastServedNext = SRV_EP;
            stateNext      = SEND;
          end
        end
        SEND: begin
          if (grantedDone || timeoutHit) begin
            stateNext  = EOP;
            eopCntNext = 2'd0;
            if (timeoutHit) lastServedNext = SRV_NONE;
          end
        end
        EOP: begin
          if (eopCnt == 2'd2) begin
            stateNext  = GAP;
            grantNext  = 3'b000;
            gapCntNext = 4'(GAP_BITS - 1);
          end else begin
            eopCntNext = eopCnt + 2'd1;
          end
        end
        GAP: begin
          if (gapCnt == 4'd0) stateNext = IDLE;
          else gapCntNext = gapCnt - 4'd1;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // outputs are decoded from the next state so they register together with it
  always_comb begin
    txBitNext = 1'b1;
    txOENext  = 1'b0;
    txSe0Next = 1'b0;
    busyNext  = 1'b1;
    unique case (stateNext)
      IDLE: busyNext = 1'b0;
      SEND: begin
        txBitNext = muxBit;
        txOENext  = muxOE;
      end
      EOP: begin
        txOENext  = 1'b1;
        txSe0Next = (eopCntNext != 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge useClk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      lastServed <= SRV_EP;
      eopCnt     <= '0;
      gapCnt     <= '0;
      grant      <= '0;
      txBit      <= 1'b1;
      txOE       <= 1'b0;
      txSe0      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= stateNext;
      lastServed <= lastServedNext;
      eopCnt     <= eopCntNext;
      gapCnt     <= gapCntNext;
      grant      <= grantNext;
      txBit      <= txBitNext;
      txOE       <= txOENext;
      txSe0      <= txSe0Next;
      busy       <= busyNext;
    end
  end

  always_ff @(posedge useClk or negedge resetN) begin
    if (!resetN) begin
      toggleDesc <= 1'b0;
      toggleEp   <= 1'b0;
    end else if (setupIn) begin
      toggleDesc <= 1'b1;
      toggleEp   <= 1'b1;
    end else if (ackIn) begin
      if (lastServed == SRV_DESC) toggleDesc <= ~toggleDesc;
      if (lastServed == SRV_EP)   toggleEp   <= ~toggleEp;
    end
  end
endmodule

// File: tb/tb_usb_tx_arbiter.sv
// tb_usb_tx_arbiter: randomized packet traffic against a strobe-indexed schedule model of the line.
module tb_usb_tx_arbiter;
  localparam int MAX_BITS = 20;
  localparam int GAP_BITS = 4;
`ifdef USB_TX_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic useClk = 1'b0, resetN = 1'b0, checkData = 1'b0;
  logic reqHs = 1'b0, reqDesc = 1'b0, reqEp = 1'b0;
  logic bitHs = 1'b0, bitDesc = 1'b0, bitEp = 1'b0;
  logic oeHs = 1'b0, oeDesc = 1'b0, oeEp = 1'b0;
  logic doneHs = 1'b0, doneDesc = 1'b0, doneEp = 1'b0;
  logic ackIn = 1'b0, setupIn = 1'b0, clrErr = 1'b0;
  logic [2:0] grant;
  logic toggleDesc, toggleEp, txBit, txOE, txSe0, busy, timeoutErr;

  usb_tx_arbiter #(.MAX_BITS(MAX_BITS), .GAP_BITS(GAP_BITS)) dut (
    .useClk(useClk), .resetN(resetN), .checkData(checkData),
    .reqHs(reqHs), .reqDesc(reqDesc), .reqEp(reqEp),
    .bitHs(bitHs), .bitDesc(bitDesc), .bitEp(bitEp),
    .oeHs(oeHs), .oeDesc(oeDesc), .oeEp(oeEp),
    .doneHs(doneHs), .doneDesc(doneDesc), .doneEp(doneEp),
    .ackIn(ackIn), .setupIn(setupIn), .clrErr(clrErr),
    .grant(grant), .toggleDesc(toggleDesc), .toggleEp(toggleEp),
    .txBit(txBit), .txOE(txOE), .txSe0(txSe0), .busy(busy), .timeoutErr(timeoutErr)
  );

  always #5 useClk = ~useClk;

  int errCnt = 0;
  int chkCnt = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: per-source pending requests and one packet schedule in strobe indices
  bit pend[3];
  int plen[3];
  bit curBit[3], curOe[3], dn[3];
  bit active, pTo;
  int pSrc, pG, pE, nextFree;
  int lastM;  // 0 none, 1 desc, 2 ep
  bit togD, togE, errM;

  // 0 idle, 1 data, 2 se0, 3 J, 4 gap
  function automatic int phase(input int t);
    if (!active) return 0;
    if (t < pE) return 1;
    if (t < pE + 2) return 2;
    if (t == pE + 2) return 3;
    if (t < pE + 3 + GAP_BITS) return 4;
    return 0;
  endfunction

  function automatic int newLen();
    if (ToEn && $urandom_range(7) == 0) return 999;
    return int'($urandom_range(12, 1));
  endfunction

  function automatic bit raiseNow(input int s, input int t);
    if (t < 60) return (t == 0);
    if (t < 120) return 1'b1;
    if (t < 160) return (s != 0);
    return ($urandom_range(4) == 0);
  endfunction

  task automatic checkLine(input int t);
    int ph;
    logic [31:0] expGrant;
    ph = phase(t);
    expGrant = (ph >= 1 && ph <= 3) ? (32'd1 << pSrc) : 32'd0;
    checkVal("grant", {29'd0, grant}, expGrant);
    checkVal("txOE", {31'd0, txOE}, (ph == 1) ? {31'd0, curOe[pSrc]} : {31'd0, (ph == 2 || ph == 3)});
    checkVal("txSe0", {31'd0, txSe0}, {31'd0, ph == 2});
    checkVal("busy", {31'd0, busy}, {31'd0, ph != 0});
    if (ph == 1) checkVal("txBit", {31'd0, txBit}, {31'd0, curBit[pSrc]});
    else if (ph == 0 || ph == 3) checkVal("txBitIdleJ", {31'd0, txBit}, 32'd1);
    checkVal("timeoutErr", {31'd0, timeoutErr}, {31'd0, errM});
  endtask

  initial begin
    int w, ev, k, ph;
    bit resetDone, longDone;
    resetDone = 1'b0;
    longDone = 1'b0;
    active = 1'b0;
    nextFree = 0;
    lastM = 2;
    togD = 1'b0;
    togE = 1'b0;
    errM = 1'b0;
    for (int s = 0; s < 3; s++) begin
      pend[s] = 1'b0;
      plen[s] = 1;
    end

    repeat (3) @(posedge useClk);
    #1;
    checkVal("rstGrant", {29'd0, grant}, 32'd0);
    checkVal("rstTxBit", {31'd0, txBit}, 32'd1);
    checkVal("rstTxOE", {31'd0, txOE}, 32'd0);
    checkVal("rstSe0", {31'd0, txSe0}, 32'd0);
    checkVal("rstBusy", {31'd0, busy}, 32'd0);
    checkVal("rstTogD", {31'd0, toggleDesc}, 32'd0);
    checkVal("rstTogE", {31'd0, toggleEp}, 32'd0);
    checkVal("rstErr", {31'd0, timeoutErr}, 32'd0);
    resetN = 1'b1;
    @(posedge useClk);
    #1;

    for (int t = 0; t < 450; t++) begin
      for (int s = 0; s < 3; s++)
        if (!pend[s] && raiseNow(s, t)) begin
          pend[s] = 1'b1;
          plen[s] = newLen();
        end

      if (t >= nextFree && (pend[0] || pend[1] || pend[2])) begin
        if (pend[0]) w = 0;
        else if (pend[1] && pend[2]) w = (lastM == 1) ? 2 : 1;
        else w = pend[1] ? 1 : 2;
        active = 1'b1;
        pSrc = w;
        pG = t;
        pTo = ToEn && (plen[w] > MAX_BITS);
        pE = t + (pTo ? MAX_BITS : plen[w]);
        nextFree = pE + GAP_BITS + 4;
        if (w != 0) lastM = w;
      end

      for (int s = 0; s < 3; s++) begin
        curBit[s] = 1'($urandom_range(1));
        curOe[s] = 1'($urandom_range(1));
        if (active && s == pSrc && t <= pE) dn[s] = (t == pE) && !pTo;
        else dn[s] = ($urandom_range(3) == 0);
      end
      reqHs = pend[0]; reqDesc = pend[1]; reqEp = pend[2];
      bitHs = curBit[0]; bitDesc = curBit[1]; bitEp = curBit[2];
      oeHs = curOe[0]; oeDesc = curOe[1]; oeEp = curOe[2];
      doneHs = dn[0]; doneDesc = dn[1]; doneEp = dn[2];
      checkData = 1'b1;
      @(posedge useClk);
      #1;
      checkData = 1'b0;
      doneHs = 1'b0; doneDesc = 1'b0; doneEp = 1'b0;

      if (active && t == pE) begin
        pend[pSrc] = 1'b0;
        if (pTo) begin
          errM = 1'b1;
          lastM = 0;
        end
      end

      ph = phase(t);
      if (ph == 1 && ((t >= 200 && !longDone) || $urandom_range(11) == 0)) begin
        k = 50;
        longDone = 1'b1;
      end else begin
        k = int'($urandom_range(3, 1));
      end

      ev = int'($urandom_range(9));
      ackIn = (ev == 0 || ev == 2);
      setupIn = (ev == 1 || ev == 2);
      clrErr = (ev == 3);
      @(posedge useClk);
      #1;
      ackIn = 1'b0; setupIn = 1'b0; clrErr = 1'b0;
      if (ev == 1 || ev == 2) begin
        togD = 1'b1;
        togE = 1'b1;
      end else if (ev == 0) begin
        if (lastM == 1) togD = !togD;
        else if (lastM == 2) togE = !togE;
      end
      if (ev == 3) errM = 1'b0;
      checkVal("toggleDesc", {31'd0, toggleDesc}, {31'd0, togD});
      checkVal("toggleEp", {31'd0, toggleEp}, {31'd0, togE});
      repeat (k - 1) @(posedge useClk);
      #1;
      checkLine(t);

      if (!resetDone && t >= 250 && ph == 1) begin
        resetDone = 1'b1;
        resetN = 1'b0;
        #1;
        checkVal("asyncGrant", {29'd0, grant}, 32'd0);
        checkVal("asyncTxOE", {31'd0, txOE}, 32'd0);
        checkVal("asyncTxBit", {31'd0, txBit}, 32'd1);
        checkVal("asyncBusy", {31'd0, busy}, 32'd0);
        @(posedge useClk);
        #1;
        resetN = 1'b1;
        active = 1'b0;
        nextFree = t + 1;
        plen[pSrc] = newLen();
        lastM = 2;
        togD = 1'b0;
        togE = 1'b0;
        errM = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end
endmodule
